// File: rtl/decode_unit.sv
// Decode/issue stage: turns the fetched 9-bit instruction into a registered micro-op and steers the fetch unit.
// Optional feature: define DECODE_UNIT_ILLEGAL_TRAP_EN to trap illegal encodings into HALT (otherwise they act as nop).
module decode_unit (
  input  logic       clk,
  input  logic       init_n,
  input  logic [8:0] inst,
  input  logic [7:0] rs_value,
  input  logic       flag_eq,
  input  logic       mem_ready,
  output logic       fetch_init,
  output logic       fetch_unit_en,
  output logic       branch,
  output logic       branchi,
  output logic [7:0] target,
  output logic [5:0] immediate,
  output logic       ex_valid,
  output logic [3:0] ex_op,
  output logic [1:0] ex_rd,
  output logic [1:0] ex_rs,
  output logic [5:0] ex_imm,
  output logic       ex_reg_we,
  output logic       ex_mem_re,
  output logic       ex_mem_we,
  output logic       halted,
  output logic       illegal
);

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_ADD   = 4'd1,
    OP_CMP   = 4'd2,
    OP_MOV   = 4'd3,
    OP_LD    = 4'd4,
    OP_ST    = 4'd5,
    OP_SH    = 4'd6,
    OP_SHLI  = 4'd7,
    OP_SHRI  = 4'd8,
    OP_MOVIL = 4'd9,
    OP_MOVIH = 4'd10,
    OP_ANDI  = 4'd11,
    OP_INC   = 4'd12
  } op_e;

  // Instruction class drives the FSM; op/rd/rs/imm/reg_we are what gets issued.
  typedef enum logic [3:0] {
    K_NOP, K_HALT, K_BEQ, K_BEQI, K_JMP, K_JMPI, K_ALU, K_LD, K_ST, K_ILLEGAL
  } kind_e;

  typedef struct packed {
    kind_e      kind;
    op_e        op;
    logic [1:0] rd;
    logic [1:0] rs;
    logic [5:0] imm;
    logic       reg_we;
  } dec_t;

  typedef enum logic [2:0] {
    S_START, S_RUN, S_STALL, S_MEM_WAIT, S_HALT
  } state_e;

  state_e state, next_state;
  dec_t   dec;
  logic   cmp_last;
  logic   fe_init, fe_en, br, bri;
  logic   issue, mem_done, set_halt;
`ifdef DECODE_UNIT_ILLEGAL_TRAP_EN
  logic   set_illegal;
`endif

  // ---------------------------------------------------------------------------
  // Instruction decode
  // ---------------------------------------------------------------------------
  // NOTE: every field gets a default before the case so no path leaves a latch.
  always_comb begin
    dec = '{kind: K_ILLEGAL, op: OP_NOP, rd: 2'd0, rs: 2'd0, imm: 6'd0, reg_we: 1'b0};
    casez (inst)
      9'b000000000: dec.kind = K_NOP;
      9'b000000001: dec.kind = K_HALT;
      9'b0000001??: dec.kind = K_BEQ;
      9'b0000010??: dec.kind = K_JMP;
      9'b0000011??: begin
        dec.kind   = K_ALU;
        dec.op     = OP_INC;
        dec.rd     = inst[1:0];
        dec.rs     = inst[1:0];
        dec.reg_we = 1'b1;
      end
      9'b00101????: begin
        dec.kind   = K_ALU;
        dec.op     = OP_ADD;
        dec.rd     = inst[3:2];
        dec.rs     = inst[1:0];
        dec.reg_we = 1'b1;
      end
      9'b00110????: begin
        dec.kind   = K_ALU;
        dec.op     = OP_CMP;
        dec.rd     = inst[3:2];
        dec.rs     = inst[1:0];
      end
      9'b00111????: begin
        dec.kind   = K_ALU;
        dec.op     = OP_MOV;
        dec.rd     = inst[3:2];
        dec.rs     = inst[1:0];
        dec.reg_we = 1'b1;
      end
      9'b01000????: begin
        dec.kind   = K_LD;
        dec.op     = OP_LD;
        dec.rd     = inst[3:2];
        dec.rs     = inst[1:0];
        dec.reg_we = 1'b1;
      end
      9'b01001????: begin
        dec.kind   = K_ST;
        dec.op     = OP_ST;
        dec.rd     = inst[3:2];
        dec.rs     = inst[1:0];
      end
      9'b01010????: begin
        dec.kind   = K_ALU;
        dec.op     = OP_SH;
        dec.rd     = inst[3:2];
        dec.rs     = inst[1:0];
        dec.reg_we = 1'b1;
      end
      9'b01011????: begin
        dec.kind = K_BEQI;
        dec.imm  = {2'b00, inst[3:0]};
      end
      9'b01100????: begin
        dec.kind   = K_ALU;
        dec.op     = OP_SHLI;
        dec.rd     = inst[3:2];
        dec.imm    = {4'b0000, inst[1:0]};
        dec.reg_we = 1'b1;
      end
      9'b01110????: begin
        dec.kind   = K_ALU;
        dec.op     = OP_SHRI;
        dec.rd     = inst[3:2];
        dec.imm    = {4'b0000, inst[1:0]};
        dec.reg_we = 1'b1;
      end
      9'b100??????: begin
        dec.kind   = K_ALU;
        dec.op     = OP_MOVIL;
        dec.rd     = inst[5:4];
        dec.imm    = {2'b00, inst[3:0]};
        dec.reg_we = 1'b1;
      end
      9'b101??????: begin
        dec.kind   = K_ALU;
        dec.op     = OP_MOVIH;
        dec.rd     = inst[5:4];
        dec.imm    = {2'b00, inst[3:0]};
        dec.reg_we = 1'b1;
      end
      9'b110??????: begin
        dec.kind   = K_ALU;
        dec.op     = OP_ANDI;
        dec.rd     = inst[5:4];
        dec.imm    = {2'b00, inst[3:0]};
        dec.reg_we = 1'b1;
      end
      9'b111??????: begin
        dec.kind = K_JMPI;
        dec.imm  = inst[5:0];
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) state <= S_START;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    fe_init    = 1'b0;
    fe_en      = 1'b0;
    br         = 1'b0;
    bri        = 1'b0;
    issue      = 1'b0;
    mem_done   = 1'b0;
    set_halt   = 1'b0;
`ifdef DECODE_UNIT_ILLEGAL_TRAP_EN
    set_illegal = 1'b0;
`endif
    case (state)
      S_START: begin
        fe_init    = 1'b1;
        fe_en      = 1'b1;
        next_state = S_RUN;
      end
      S_RUN: begin
        case (dec.kind)
          K_NOP: fe_en = 1'b1;
          K_HALT: begin
            set_halt   = 1'b1;
            next_state = S_HALT;
          end
          K_BEQ, K_BEQI: begin
            // flag_eq is not valid yet right after a cmp: hold fetch one cycle.
            if (cmp_last) begin
              next_state = S_STALL;
            end else begin
              fe_en = 1'b1;
              br    = (dec.kind == K_BEQ)  && flag_eq;
              bri   = (dec.kind == K_BEQI) && flag_eq;
            end
          end
          K_JMP: begin
            fe_en = 1'b1;
            br    = 1'b1;
          end
          K_JMPI: begin
            fe_en = 1'b1;
            bri   = 1'b1;
          end
          K_ALU: begin
            fe_en = 1'b1;
            issue = 1'b1;
          end
          K_LD, K_ST: begin
            issue      = 1'b1;
            next_state = S_MEM_WAIT;
          end
          default: begin
`ifdef DECODE_UNIT_ILLEGAL_TRAP_EN
            set_illegal = 1'b1;
            set_halt    = 1'b1;
            next_state  = S_HALT;
`else
            fe_en = 1'b1;
`endif
          end
        endcase
      end
      S_STALL: begin
        // pc was held, so inst is still the branch that caused the stall.
        fe_en      = 1'b1;
        br         = (dec.kind == K_BEQ)  && flag_eq;
        bri        = (dec.kind == K_BEQI) && flag_eq;
        next_state = S_RUN;
      end
      S_MEM_WAIT: begin
        fe_en = mem_ready;
        if (mem_ready) begin
          mem_done   = 1'b1;
          next_state = S_RUN;
        end
      end
      S_HALT: ;
      default: next_state = S_START;
    endcase
  end

  // Fetch controls are forced low while reset is held.
  assign fetch_init    = init_n & fe_init;
  assign fetch_unit_en = init_n & fe_en;
  assign branch        = init_n & br;
  assign branchi       = init_n & bri;
  assign target        = rs_value;
  assign immediate     = dec.imm;

  // ---------------------------------------------------------------------------
  // Issue register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      ex_valid  <= 1'b0;
      ex_op     <= 4'd0;
      ex_rd     <= 2'd0;
      ex_rs     <= 2'd0;
      ex_imm    <= 6'd0;
      ex_reg_we <= 1'b0;
      ex_mem_re <= 1'b0;
      ex_mem_we <= 1'b0;
      cmp_last  <= 1'b0;
      halted    <= 1'b0;
`ifdef DECODE_UNIT_ILLEGAL_TRAP_EN
      illegal   <= 1'b0;
`endif
    end else begin
      ex_valid <= issue;
      cmp_last <= issue && (dec.op == OP_CMP);
      if (issue) begin
        ex_op     <= dec.op;
        ex_rd     <= dec.rd;
        ex_rs     <= dec.rs;
        ex_imm    <= dec.imm;
        ex_reg_we <= dec.reg_we;
        ex_mem_re <= (dec.kind == K_LD);
        ex_mem_we <= (dec.kind == K_ST);
      end else if (mem_done) begin
        ex_mem_re <= 1'b0;
        ex_mem_we <= 1'b0;
      end
      if (set_halt) halted <= 1'b1;
`ifdef DECODE_UNIT_ILLEGAL_TRAP_EN
      if (set_illegal) illegal <= 1'b1;
`endif
    end
  end

`ifndef DECODE_UNIT_ILLEGAL_TRAP_EN
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_decode_unit.sv
// Directed bench for decode_unit: the bench plays the fetch unit, issued micro-ops are
// checked against a scoreboard queue filled when each instruction is driven.
module tb_decode_unit;

  logic       clk = 1'b0;
  logic       init_n = 1'b0;
  logic [8:0] inst = 9'd0;
  logic [7:0] rs_value = 8'd0;
  logic       flag_eq = 1'b0;
  logic       mem_ready = 1'b0;
  logic       fetch_init, fetch_unit_en, branch, branchi;
  logic [7:0] target;
  logic [5:0] immediate;
  logic       ex_valid;
  logic [3:0] ex_op;
  logic [1:0] ex_rd, ex_rs;
  logic [5:0] ex_imm;
  logic       ex_reg_we, ex_mem_re, ex_mem_we, halted, illegal;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [3:0] op;
    logic [1:0] rd;
    logic [1:0] rs;
    logic [5:0] imm;
    logic       we;
    logic       re;
    logic       mwe;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  decode_unit dut (
    .clk          (clk),
    .init_n       (init_n),
    .inst         (inst),
    .rs_value     (rs_value),
    .flag_eq      (flag_eq),
    .mem_ready    (mem_ready),
    .fetch_init   (fetch_init),
    .fetch_unit_en(fetch_unit_en),
    .branch       (branch),
    .branchi      (branchi),
    .target       (target),
    .immediate    (immediate),
    .ex_valid     (ex_valid),
    .ex_op        (ex_op),
    .ex_rd        (ex_rd),
    .ex_rs        (ex_rs),
    .ex_imm       (ex_imm),
    .ex_reg_we    (ex_reg_we),
    .ex_mem_re    (ex_mem_re),
    .ex_mem_we    (ex_mem_we),
    .halted       (halted),
    .illegal      (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic push(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs,
                      input logic [5:0] imm, input logic we, input logic re, input logic mwe);
    sb.push_back('{op: op, rd: rd, rs: rs, imm: imm, we: we, re: re, mwe: mwe});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_inst(input logic [8:0] i);
    inst = i;
    #1;
  endtask

  // Reset pulse placed mid-cycle; returns before the next rising edge in START.
  task automatic do_reset();
    init_n = 1'b0;
    #1;
    check("rst_fetch_ctl", {fetch_init, fetch_unit_en, branch, branchi}, 4'b0000);
    check("rst_regs", {ex_valid, ex_mem_re, ex_mem_we, halted, illegal}, 5'b00000);
    init_n = 1'b1;
    #1;
    check("start_fetch_init", {fetch_init, fetch_unit_en}, 2'b11);
  endtask

  // Scoreboard: every issue strobe must match the oldest pending expectation.
  always @(posedge clk) begin
    #1;
    if (ex_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_issue", {31'd0, ex_valid}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("issue", {ex_op, ex_rd, ex_rs, ex_imm, ex_reg_we, ex_mem_re, ex_mem_we}, mon_e);
      end
    end
  end

  initial begin
    // Reset state.
    #12;
    check("reset_fetch_ctl", {fetch_init, fetch_unit_en, branch, branchi}, 4'b0000);
    check("reset_ex", {ex_valid, ex_op, ex_rd, ex_rs, ex_imm, ex_reg_we, ex_mem_re, ex_mem_we}, 18'd0);
    check("reset_sticky", {halted, illegal}, 2'b00);
    #10;
    init_n = 1'b1;
    #1;
    check("start_cycle", {fetch_init, fetch_unit_en, branch, branchi}, 4'b1100);

    // movih r0,0 issues one cycle after the START cycle.
    set_inst(9'b101000000);
    push(4'd10, 2'd0, 2'd0, 6'd0, 1'b1, 1'b0, 1'b0);
    tick();
    check("start_no_issue", {31'd0, ex_valid}, 32'd0);
    check("run_fetch_en", {fetch_init, fetch_unit_en}, 2'b01);
    tick();
    check("movih_valid", {31'd0, ex_valid}, 32'd1);

    // ld r1,[r0] with mem_ready on the 3rd MEM_WAIT cycle.
    set_inst(9'b010000100);
    push(4'd4, 2'd1, 2'd0, 6'd0, 1'b1, 1'b1, 1'b0);
    check("ld_run_en", {31'd0, fetch_unit_en}, 32'd0);
    tick();
    check("mw1", {ex_mem_re, fetch_unit_en}, 2'b10);
    tick();
    check("mw2", {ex_valid, ex_mem_re, fetch_unit_en}, 3'b010);
    tick();
    mem_ready = 1'b1;
    #1;
    check("mw3", {ex_valid, ex_mem_re, fetch_unit_en}, 3'b011);
    tick();
    mem_ready = 1'b0;
    check("mw_done", {ex_mem_re, ex_mem_we}, 2'b00);
    set_inst(9'b001011011);
    push(4'd1, 2'd2, 2'd3, 6'd0, 1'b1, 1'b0, 1'b0);
    check("after_ld_en", {31'd0, fetch_unit_en}, 32'd1);
    tick();

    // cmp then beqi 3 with flag_eq=1: one bubble, then taken.
    set_inst(9'b001100000);
    push(4'd2, 2'd0, 2'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    tick();
    flag_eq = 1'b1;
    set_inst(9'b010110011);
    check("beqi_hold", {fetch_unit_en, branchi}, 2'b00);
    tick();
    check("stall_taken", {fetch_unit_en, branch, branchi, 26'd0, immediate}, {3'b101, 26'd0, 6'd3});
    check("stall_bubble", {31'd0, ex_valid}, 32'd0);
    tick();
    check("beqi_no_issue", {31'd0, ex_valid}, 32'd0);
    flag_eq = 1'b0;
    #1;
    check("beqi_not_taken", {fetch_unit_en, branchi}, 2'b10);
    flag_eq = 1'b1;
    #1;
    check("beqi_taken_nostall", {fetch_unit_en, branchi}, 2'b11);
    tick();

    // jmp r0 and beq r1 without a preceding cmp, then jmpi 5.
    rs_value = 8'h15;
    set_inst(9'b000001000);
    check("jmp", {fetch_unit_en, branch, branchi, target}, {3'b110, 8'h15});
    tick();
    check("jmp_no_issue", {31'd0, ex_valid}, 32'd0);
    set_inst(9'b000000101);
    check("beq_taken", {fetch_unit_en, branch, branchi}, 3'b110);
    tick();
    flag_eq = 1'b0;
    set_inst(9'b111000101);
    check("jmpi", {fetch_unit_en, branch, branchi, immediate}, {3'b101, 6'd5});
    tick();

    // A mix of plain register-writing ops.
    set_inst(9'b000001110);
    push(4'd12, 2'd2, 2'd2, 6'd0, 1'b1, 1'b0, 1'b0);
    tick();
    set_inst(9'b100011010);
    push(4'd9, 2'd1, 2'd0, 6'hA, 1'b1, 1'b0, 1'b0);
    tick();
    set_inst(9'b011101110);
    push(4'd8, 2'd3, 2'd0, 6'd2, 1'b1, 1'b0, 1'b0);
    tick();

    // st with memory ready on the first wait cycle.
    set_inst(9'b010011001);
    push(4'd5, 2'd2, 2'd1, 6'd0, 1'b0, 1'b0, 1'b1);
    tick();
    mem_ready = 1'b1;
    #1;
    check("st_mw1", {ex_mem_we, fetch_unit_en}, 2'b11);
    tick();
    mem_ready = 1'b0;
    check("st_done", {31'd0, ex_mem_we}, 32'd0);

    // Illegal encoding.
    set_inst(9'b011010000);
`ifdef DECODE_UNIT_ILLEGAL_TRAP_EN
    check("illegal_run_en", {31'd0, fetch_unit_en}, 32'd0);
    tick();
    check("illegal_trap", {illegal, halted, ex_valid}, 3'b110);
`else
    check("illegal_as_nop", {31'd0, fetch_unit_en}, 32'd1);
    tick();
    check("illegal_nop", {illegal, halted, ex_valid}, 3'b000);
`endif

    // halt, stays halted, reset clears it.
    do_reset();
    set_inst(9'b000000001);
    tick();
    check("halt_run_en", {31'd0, fetch_unit_en}, 32'd0);
    tick();
    check("halted_set", {halted, ex_valid}, 2'b10);
    set_inst(9'b101000000);
    for (int i = 0; i < 3; i++) begin
      check("halt_fetch_ctl", {fetch_init, fetch_unit_en, branch, branchi}, 4'b0000);
      tick();
    end
    check("halt_no_issue", {31'd0, ex_valid}, 32'd0);
    do_reset();

    // Reset during MEM_WAIT drops the memory request at once.
    set_inst(9'b010000100);
    push(4'd4, 2'd1, 2'd0, 6'd0, 1'b1, 1'b1, 1'b0);
    tick();
    tick();
    check("mw_pre_abort", {31'd0, ex_mem_re}, 32'd1);
    init_n = 1'b0;
    #1;
    check("mw_abort", {ex_mem_re, ex_valid, fetch_unit_en}, 3'b000);
    init_n = 1'b1;
    #1;
    check("abort_start", {31'd0, fetch_init}, 32'd1);
    set_inst(9'b000000000);
    tick();
    tick();
    tick();

    check("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_unit.md
# decode_unit

Decode/issue stage that sits directly downstream of the fetch unit. It consumes the 9-bit instruction the fetch unit presents combinationally for the current pc, and decodes it into a registered micro-op for the execute stage. It also drives the fetch unit's control inputs (enable, init, branch, branchi, target, immediate). It owns the startup sequence, the stall after a cmp, the load/store memory wait, and halt.

## Interface
- No parameters.
- clk  in  1  clock, rising edge
- init_n  in  1  asynchronous active-low reset
- inst  in  9  instruction from fetch unit (combinational of pc)
- rs_value  in  8  register-file read of r[inst[1:0]], combinational
- flag_eq  in  1  execute-stage equal flag; valid from the cycle after a cmp issues
- mem_ready  in  1  data-memory completion, sampled only in MEM_WAIT
- fetch_init, fetch_unit_en, branch, branchi  out  1  fetch control, combinational
- target  out  8  jump target (= rs_value)
- immediate  out  6  pc-relative offset, zero-extended imm
- ex_valid  out  1  registered; one-cycle issue strobe
- ex_op  out  4  registered; 0 NOP, 1 ADD, 2 CMP, 3 MOV, 4 LD, 5 ST, 6 SH, 7 SHLI, 8 SHRI, 9 MOVIL, 10 MOVIH, 11 ANDI, 12 INC
- ex_rd, ex_rs  out  2  registered register indices
- ex_imm  out  6  registered zero-extended immediate
- ex_reg_we, ex_mem_re, ex_mem_we  out  1  registered
- halted, illegal  out  1  registered, sticky

## Operation
- Decode rules:
  - 000000000: nop.
  - 000000001: halt.
  - 0000001rr: beq rN.
  - 0000010rr: jmp rN.
  - 0000011rr: inc rN.
  - 00101ddss: add. 00110ddss: cmp. 00111ddss: mov.
  - 01000ddss: ld rd <- mem[rs]. 01001ddss: st mem[rs] <- rd. 01010ddss: sh.
  - 01011iiii: beqi.
  - 01100ddii: shli. 01110ddii: shri.
  - 100ddiiii: movil. 101ddiiii: movih. 110ddiiii: andi.
  - 111iiiiii: jmpi.
  - All other encodings are illegal.
- ex_reg_we is 1 for add, mov, ld, sh, shli, shri, movil, movih, andi and inc. It is 0 for cmp and st.
- The jmp, jmpi, beq, beqi, halt and nop instructions issue nothing: ex_valid stays 0 for them.
- States:
  - START: fetch_init=1, fetch_unit_en=1, no issue. Next state is RUN.
  - RUN: decode inst.
    - Plain ops: issue, fetch_unit_en=1.
    - jmp: branch=1. jmpi: branchi=1. Both with fetch_unit_en=1.
    - beq/beqi when the previous cycle issued a cmp (cmp_last=1): fetch_unit_en=0, go to STALL.
    - beq/beqi otherwise: branch/branchi = flag_eq, fetch_unit_en=1.
    - ld/st: issue with ex_mem_re/ex_mem_we set, fetch_unit_en=0, go to MEM_WAIT.
    - halt: fetch_unit_en=0, halted<=1, go to HALT.
  - STALL: resolve beq/beqi on flag_eq, fetch_unit_en=1, go to RUN.
  - MEM_WAIT: ex_valid=0; ex_mem_re/ex_mem_we hold. fetch_unit_en = mem_ready. On mem_ready=1: clear ex_mem_*, go to RUN.
  - HALT: all fetch controls are 0. The only exit is reset.
- cmp_last is set when a cmp issues and cleared by any other cycle, so it covers only the immediately following instruction.
- target and immediate are always driven from the current inst/rs_value. They only matter when branch or branchi is 1.

## Timing
- Reset (init_n low, asynchronous) clears state to START, every registered output to 0, and cmp_last to 0. While init_n is low, all fetch controls are forced to 0.
- First edge after reset release: the fetch unit loads the start address. The first instruction is decoded in the following cycle.
- Issue latency is 1 cycle: ex_* update on the edge that ends the decode cycle.
- A taken branch has no delay slot, because the fetch unit takes target or pc+immediate on the same edge.
- Stall costs:
  - cmp followed by beq/beqi: exactly 1 bubble.
  - ld/st: the instruction occupies 1 + N cycles, where N is the number of MEM_WAIT cycles up to and including the one with mem_ready.
- A reset during MEM_WAIT or STALL aborts the operation immediately. ex_mem_* drop asynchronously.

## Configuration
- DECODE_UNIT_ILLEGAL_TRAP_EN defined: an illegal encoding sets illegal<=1 and halted<=1, enters HALT, and issues nothing.
- Undefined: an illegal encoding is treated as nop (fetch advances, nothing issues) and illegal is tied to 0.

## Test plan
- Reset release, then inst=101000000 (movih r0 0) → START cycle with fetch_init=1, then ex_op=10, ex_rd=0, ex_imm=0, ex_reg_we=1, ex_valid=1.
- Program ld (010000100) with mem_ready asserted on the 3rd MEM_WAIT cycle → ex_op=4, ex_rd=1, ex_rs=0, ex_mem_re high for 3 cycles, fetch_unit_en low for 3 cycles then high, next instruction issues.
- cmp (001100000) then beqi 3 (010110011) with flag_eq=1 → one bubble, then branchi=1, immediate=3, no issue for the beqi.
- jmp r0 (000001000) with rs_value=8'h15 → branch=1, target=8'h15, fetch_unit_en=1, ex_valid=0.
- halt (000000001) → halted=1 from the next edge, fetch_unit_en=0 for all later cycles; a reset pulse clears halted and re-enters START.
- Illegal encoding 011010000:
  - Macro defined: illegal=1, halted=1.
  - Macro undefined: treated as nop, pc advances, illegal=0.
